// File: rtl/pixel_sequencer.sv
// rtl/pixel_sequencer.sv - frame sequencer: erase, expose, convert (Gray ramp), NUM_READ read slots
module pixel_sequencer #(
  parameter int NUM_READ = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                continuous,
  input  logic                stop,
  input  logic                abort,
  input  logic [CNT_W-1:0]    erase_cycles,
  input  logic [CNT_W-1:0]    expose_cycles,
  input  logic [CNT_W-1:0]    convert_cycles,
  input  logic [CNT_W-1:0]    read_cycles,
  output logic                erase,
  output logic                expose,
  output logic                convert,
  output logic [NUM_READ-1:0] read_sel,
  output logic [CNT_W-1:0]    gray_count,
  output logic                busy,
  output logic                frame_done
);

  localparam int IDX_W = (NUM_READ > 1) ? $clog2(NUM_READ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_READ - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      dur_e_q, dur_e_d, dur_x_q, dur_x_d;
  logic [CNT_W-1:0]      dur_c_q, dur_c_d, dur_r_q, dur_r_d;
  logic                  cont_q, cont_d;
  logic                  done_d;
  logic [CNT_W-1:0]      dur;
  logic                  phase_last;
  logic                  latch;

  logic                  erase_q, erase_d, expose_q, expose_d, convert_q, convert_d;
  logic                  busy_q, busy_d, frame_done_q;
  logic [NUM_READ-1:0]   read_sel_q, read_sel_d;
  logic [CNT_W-1:0]      gray_q, gray_d;

  // A programmed duration of 0 behaves as 1, so the final count is max(D-1, 0).
  function automatic logic [CNT_W-1:0] last_cnt(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      dur_e_q      <= '0;
      dur_x_q      <= '0;
      dur_c_q      <= '0;
      dur_r_q      <= '0;
      cont_q       <= 1'b0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      convert_q    <= 1'b0;
      read_sel_q   <= '0;
      gray_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      dur_e_q      <= dur_e_d;
      dur_x_q      <= dur_x_d;
      dur_c_q      <= dur_c_d;
      dur_r_q      <= dur_r_d;
      cont_q       <= cont_d;
      erase_q      <= erase_d;
      expose_q     <= expose_d;
      convert_q    <= convert_d;
      read_sel_q   <= read_sel_d;
      gray_q       <= gray_d;
      busy_q       <= busy_d;
      frame_done_q <= done_d;
    end
  end

  always_comb begin
    dur = '0;
    case (state_q)
      S_ERASE:   dur = dur_e_q;
      S_EXPOSE:  dur = dur_x_q;
      S_CONVERT: dur = dur_c_q;
      S_READ:    dur = dur_r_q;
      default:   dur = '0;
    endcase
    phase_last = (cnt_q == last_cnt(dur));

    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    latch   = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (start) begin
          state_d = S_ERASE;
          latch   = 1'b1;
        end
      end
      S_ERASE: if (phase_last) begin
        state_d = S_EXPOSE;
        cnt_d   = '0;
      end
      S_EXPOSE: if (phase_last) begin
        state_d = S_CONVERT;
        cnt_d   = '0;
      end
      S_CONVERT: if (phase_last) begin
        state_d = S_READ;
        cnt_d   = '0;
        idx_d   = '0;
      end
      S_READ: if (phase_last) begin
        cnt_d = '0;
        if (idx_q == LAST_IDX) begin
          done_d = 1'b1;
          idx_d  = '0;
          if (cont_q && !stop) begin
            state_d = S_ERASE;
            latch   = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      latch   = 1'b0;
      done_d  = 1'b0;
    end

    dur_e_d = latch ? erase_cycles   : dur_e_q;
    dur_x_d = latch ? expose_cycles  : dur_x_q;
    dur_c_d = latch ? convert_cycles : dur_c_q;
    dur_r_d = latch ? read_cycles    : dur_r_q;
    cont_d  = latch ? continuous     : cont_q;
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    erase_d    = (state_d == S_ERASE);
    expose_d   = (state_d == S_EXPOSE);
    convert_d  = (state_d == S_CONVERT);
    busy_d     = (state_d != S_IDLE);
    read_sel_d = (state_d == S_READ) ? (NUM_READ'(1) << idx_d) : '0;
    gray_d     = (state_d == S_CONVERT) ? (cnt_d ^ (cnt_d >> 1)) : '0;
  end

  assign erase      = erase_q;
  assign expose     = expose_q;
  assign convert    = convert_q;
  assign read_sel   = read_sel_q;
  assign gray_count = gray_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_sequencer.sv
// tb/tb_pixel_sequencer.sv - directed, table-driven bench for pixel_sequencer
module tb_pixel_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0, continuous = 1'b0, stop = 1'b0, abort = 1'b0;
  logic [7:0] erase_cycles = '0, expose_cycles = '0, convert_cycles = '0, read_cycles = '0;
  logic       erase, expose, convert, busy, frame_done;
  logic [3:0] read_sel;
  logic [7:0] gray_count;
  logic [16:0] outs_all;

  int checks = 0;
  int failures = 0;

  pixel_sequencer #(.NUM_READ(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .stop(stop), .abort(abort),
    .erase_cycles(erase_cycles), .expose_cycles(expose_cycles),
    .convert_cycles(convert_cycles), .read_cycles(read_cycles),
    .erase(erase), .expose(expose), .convert(convert), .read_sel(read_sel),
    .gray_count(gray_count), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign outs_all = {erase, expose, convert, read_sel, gray_count, busy, frame_done};

  typedef struct {
    logic [7:0] e, x, c, r;
    int         ee, ex, ec, er, eb;
  } frame_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_dur(input logic [7:0] e, x, c, r);
    erase_cycles = e; expose_cycles = x; convert_cycles = c; read_cycles = r;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_frame(input frame_vec_t v, input int row);
    int ce, cx, cc, cb, ovl, gerr, oerr, fdc, k, n, code, prev;
    int cr[4];
    ce = 0; cx = 0; cc = 0; cb = 0; ovl = 0; gerr = 0; oerr = 0; fdc = 0;
    k = 0; n = 0; prev = 0;
    for (int i = 0; i < 4; i++) cr[i] = 0;
    continuous = 1'b0; stop = 1'b0;
    set_dur(v.e, v.x, v.c, v.r);
    pulse_start();
    set_dur(8'd1, 8'd1, 8'd1, 8'd1);
    while (busy === 1'b1 && n < 2000) begin
      code = prev;
      cb++;
      if ($countones({erase, expose, convert, read_sel}) != 1) ovl++;
      if (erase) begin ce++; code = 0; end
      else if (expose) begin cx++; code = 1; end
      else if (convert) begin
        cc++; code = 2;
        if (gray_count !== 8'(k ^ (k >> 1))) gerr++;
        k++;
      end else begin
        for (int i = 0; i < 4; i++) if (read_sel[i]) begin cr[i]++; code = 3 + i; end
      end
      if (!convert && gray_count != 8'd0) gerr++;
      if (code < prev) oerr++;
      prev = code;
      if (frame_done) fdc++;
      @(negedge clk); n++;
    end
    check($sformatf("row%0d frame_done_end", row), 32'(frame_done), 1);
    check($sformatf("row%0d erase_len", row), ce, v.ee);
    check($sformatf("row%0d expose_len", row), cx, v.ex);
    check($sformatf("row%0d convert_len", row), cc, v.ec);
    for (int i = 0; i < 4; i++) check($sformatf("row%0d read%0d_len", row, i), cr[i], v.er);
    check($sformatf("row%0d busy_len", row), cb, v.eb);
    check($sformatf("row%0d overlap_or_gap", row), ovl, 0);
    check($sformatf("row%0d gray_errs", row), gerr, 0);
    check($sformatf("row%0d order_errs", row), oerr, 0);
    check($sformatf("row%0d early_frame_done", row), fdc, 0);
    @(negedge clk);
    check($sformatf("row%0d idle_after", row), 32'(outs_all), 0);
  endtask

  initial begin
    frame_vec_t vecs[5];
    logic [7:0] gexp[8];
    int n, i, fdc, bc, nz;

    vecs[0] = '{e:8'd5, x:8'd255, c:8'd255, r:8'd10, ee:5, ex:255, ec:255, er:10, eb:555};
    vecs[1] = '{e:8'd0, x:8'd0,   c:8'd0,   r:8'd0,  ee:1, ex:1,   ec:1,   er:1,  eb:7};
    vecs[2] = '{e:8'd1, x:8'd2,   c:8'd3,   r:8'd4,  ee:1, ex:2,   ec:3,   er:4,  eb:22};
    vecs[3] = '{e:8'd3, x:8'd0,   c:8'd2,   r:8'd0,  ee:3, ex:1,   ec:2,   er:1,  eb:10};
    vecs[4] = '{e:8'd0, x:8'd7,   c:8'd1,   r:8'd2,  ee:1, ex:7,   ec:1,   er:2,  eb:17};
    gexp = '{8'd0, 8'd1, 8'd3, 8'd2, 8'd6, 8'd7, 8'd5, 8'd4};

    // reset state
    @(negedge clk); @(negedge clk);
    check("in_reset_outputs", 32'(outs_all), 0);
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    check("post_reset_outputs", 32'(outs_all), 0);

    for (int r = 0; r < 5; r++) run_frame(vecs[r], r);

    // Gray ramp with convert=8
    set_dur(8'd1, 8'd1, 8'd8, 8'd1);
    pulse_start();
    n = 0;
    while (convert !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("gray_convert_reached", 32'(convert), 1);
    for (int j = 0; j < 8; j++) begin
      check($sformatf("gray_step%0d", j), {convert, gray_count}, {1'b1, gexp[j]});
      @(negedge clk);
    end
    check("gray_after_convert", {convert, gray_count, read_sel}, 13'b0_00000000_0001);
    n = 0;
    while (busy === 1'b1 && n < 50) begin @(negedge clk); n++; end

    // continuous, stop raised during frame 2
    set_dur(8'd2, 8'd2, 8'd2, 8'd2);
    continuous = 1'b1; stop = 1'b0;
    pulse_start();
    i = 0; fdc = 0; bc = 0;
    while (i < 100) begin
      if (frame_done) fdc++;
      if (i == 14) check("cont_back_to_back", {erase, busy, frame_done}, 3'b111);
      if (!busy) break;
      bc++;
      if (i == 20) stop = 1'b1;
      @(negedge clk); i++;
    end
    check("cont_busy_len", bc, 28);
    check("cont_frame_done_count", fdc, 2);
    stop = 1'b0; continuous = 1'b0;
    @(negedge clk);
    check("cont_idle_after", 32'(outs_all), 0);

    // abort during read slot 2
    set_dur(8'd1, 8'd1, 8'd1, 8'd3);
    pulse_start();
    n = 0;
    while (read_sel !== 4'b0100 && n < 50) begin @(negedge clk); n++; end
    check("abort_slot2_reached", 32'(read_sel), 32'h4);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_outputs_zero", 32'(outs_all), 0);
    nz = 0;
    for (int j = 0; j < 6; j++) begin @(negedge clk); if (outs_all != 17'd0) nz++; end
    check("abort_stays_idle", nz, 0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("start_with_abort_idle", 32'(outs_all), 0);
    pulse_start();
    check("restart_erase", {erase, busy, read_sel}, 6'b11_0000);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;

    // asynchronous reset mid-EXPOSE
    set_dur(8'd2, 8'd10, 8'd2, 8'd2);
    pulse_start();
    n = 0;
    while (expose !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("reset_expose_reached", 32'(expose), 1);
    @(negedge clk);
    #3 reset = 1'b0;
    #1 check("async_reset_immediate", 32'(outs_all), 0);
    @(negedge clk);
    #2 reset = 1'b1;
    nz = 0;
    for (int j = 0; j < 5; j++) begin @(negedge clk); if (outs_all != 17'd0) nz++; end
    check("post_async_reset_idle", nz, 0);
    pulse_start();
    check("post_reset_start", {erase, busy}, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
